// File: rtl/ms_alu_pkg.sv
// ms_alu_pkg: FN codes, sequencer states and default width shared by the controller and the ALU
package ms_alu_pkg;
  localparam int DEF_WIDTH = 10;
  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_SUB = 3'b001;
  localparam logic [2:0] FN_INV = 3'b010;
  localparam logic [2:0] FN_AND = 3'b011;
  localparam logic [2:0] FN_OR  = 3'b100;
  localparam logic [2:0] FN_XOR = 3'b101;
  typedef enum logic [2:0] {IDLE, LOADA, EXEC, OUTG, CAPT} state_e;
  function automatic logic fn_legal(input logic [2:0] f);
    return f <= FN_XOR;
  endfunction
endpackage

// File: rtl/ms_alu_ctrl_if.sv
// ms_alu_ctrl_if: front-end request/result bus plus ALU strobe bus of the sequencer
// MS_ALU_CTRL_STATUS_EN adds the Zero/Neg result flags.
interface ms_alu_ctrl_if import ms_alu_pkg::*; #(parameter int WIDTH = DEF_WIDTH) ();
  logic Start, Busy, Done, Err, Ain, Gin, Gout;
  logic [2:0] FNin, FN;
  logic [WIDTH-1:0] OpA, OpB, Res, OP, Q;
`ifdef MS_ALU_CTRL_STATUS_EN
  logic Zero, Neg;
  modport master (output Start, FNin, OpA, OpB, Q,
                  input Busy, Done, Err, Res, OP, FN, Ain, Gin, Gout, Zero, Neg);
  modport slave (input Start, FNin, OpA, OpB, Q,
                 output Busy, Done, Err, Res, OP, FN, Ain, Gin, Gout, Zero, Neg);
`else
  modport master (output Start, FNin, OpA, OpB, Q,
                  input Busy, Done, Err, Res, OP, FN, Ain, Gin, Gout);
  modport slave (input Start, FNin, OpA, OpB, Q,
                 output Busy, Done, Err, Res, OP, FN, Ain, Gin, Gout);
`endif
endinterface

// File: rtl/ms_alu_ctrl.sv
// ms_alu_ctrl: sequences one ALU operation per Start through load/execute/output strobes, all on CLKb falling edges
// MS_ALU_CTRL_STATUS_EN adds registered Zero/Neg flags of the captured result.
module ms_alu_ctrl import ms_alu_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic CLKb,
  input logic Rst,
  ms_alu_ctrl_if.slave bus
);
  state_e state_q, state_d;
  logic [2:0] code_q, code_d, fn_q, fn_d;
  logic [WIDTH-1:0] opb_q, opb_d, op_q, op_d, res_q, res_d;
  logic ain_q, ain_d, gin_q, gin_d, gout_q, gout_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
`ifdef MS_ALU_CTRL_STATUS_EN
  logic zero_q, zero_d, neg_q, neg_d;
`endif
  // Outputs are computed for the state being entered, so every strobe is a clean register output.
  always_comb begin
    state_d = state_q;
    code_d = code_q;
    opb_d = opb_q;
    op_d = op_q;
    fn_d = fn_q;
    res_d = res_q;
    ain_d = 1'b0;
    gin_d = 1'b0;
    gout_d = 1'b0;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = 1'b0;
`ifdef MS_ALU_CTRL_STATUS_EN
    zero_d = zero_q;
    neg_d = neg_q;
`endif
    case (state_q)
      IDLE: if (bus.Start) begin
        code_d = bus.FNin;
        opb_d = bus.OpB;
        if (!fn_legal(bus.FNin)) begin
          done_d = 1'b1;
          err_d = 1'b1;
        end else if (bus.FNin == FN_INV) begin
          state_d = EXEC;
          op_d = bus.OpB;
          fn_d = bus.FNin;
          gin_d = 1'b1;
          busy_d = 1'b1;
        end else begin
          state_d = LOADA;
          op_d = bus.OpA;
          ain_d = 1'b1;
          busy_d = 1'b1;
        end
      end
      LOADA: begin
        state_d = EXEC;
        op_d = opb_q;
        fn_d = code_q;
        gin_d = 1'b1;
      end
      EXEC: begin
        state_d = OUTG;
        gout_d = 1'b1;
      end
      OUTG: state_d = CAPT;
      CAPT: begin
        state_d = IDLE;
        res_d = bus.Q;
        done_d = 1'b1;
        busy_d = 1'b0;
`ifdef MS_ALU_CTRL_STATUS_EN
        zero_d = bus.Q == '0;
        neg_d = bus.Q[WIDTH-1];
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(negedge CLKb) begin
    if (Rst) begin
      state_q <= IDLE;
      code_q <= '0;
      opb_q <= '0;
      op_q <= '0;
      fn_q <= '0;
      res_q <= '0;
      ain_q <= 1'b0;
      gin_q <= 1'b0;
      gout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
`ifdef MS_ALU_CTRL_STATUS_EN
      zero_q <= 1'b0;
      neg_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      code_q <= code_d;
      opb_q <= opb_d;
      op_q <= op_d;
      fn_q <= fn_d;
      res_q <= res_d;
      ain_q <= ain_d;
      gin_q <= gin_d;
      gout_q <= gout_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
`ifdef MS_ALU_CTRL_STATUS_EN
      zero_q <= zero_d;
      neg_q <= neg_d;
`endif
    end
  end
  assign bus.OP = op_q;
  assign bus.FN = fn_q;
  assign bus.Ain = ain_q;
  assign bus.Gin = gin_q;
  assign bus.Gout = gout_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.Err = err_q;
  assign bus.Res = res_q;
`ifdef MS_ALU_CTRL_STATUS_EN
  assign bus.Zero = zero_q;
  assign bus.Neg = neg_q;
`endif
endmodule
